imem_fetch_loader: RTL and testbench

Parametrised instruction memory with a multi-word fetch port and a streaming loader.
- Fetch side: the PC-driven fetch stage reads FETCH_W consecutive instructions per request with 1-cycle latency. Fetch honours halt.
- Load side: a valid/ready word stream loads a program image from a base address, replacing the external single-address write path.
- Sits between the PC/fetch stage and the program-load interface of the core.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_bank.sv | 48 ++++
 rtl/imem_fetch_loader.sv | 195 +++++++++++++++++++
 tb/tb_imem_fetch_loader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared types and helpers for the instruction memory / program loader.
//   load_state_t : loader FSM states (IDLE, LOAD, DONE)
//   clog2_f      : ceil(log2(v)), used to size the bank index field
// ---------------------------------------------------------------------------
package imem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } load_state_t;

   // ceil(log2(v)); returns 0 for v <= 1 so a single bank needs no index bits
   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < v) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/imem_bank.sv
// ---------------------------------------------------------------------------
// imem_bank
// One interleaved bank of the instruction memory: 2**ROW_W x DATA_W RAM with
// one synchronous read port and one write port. Contents are never reset;
// only the read data register is cleared so the fetch output starts at zero.
//   clk, rst_n : clock, synchronous active-low reset (read register only)
//   re, raddr  : read enable / row address, data appears next cycle on rdata
//   we, waddr, wdata : write enable / row address / data
//   rdata      : registered read data, holds while re is low
// ---------------------------------------------------------------------------
module imem_bank #(
   parameter int ROW_W  = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              re,
   input  logic [ROW_W-1:0]  raddr,
   input  logic              we,
   input  logic [ROW_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int ROWS = 2 ** ROW_W;

   logic [DATA_W-1:0] mem_r [ROWS];
   logic [DATA_W-1:0] rdata_r;

   // Storage write port; deliberately free of reset so contents survive it
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Synchronous read register; holds its value when no read is issued
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata_r <= '0;
      end else if (re) begin
         rdata_r <= mem_r[raddr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/imem_fetch_loader.sv
// ---------------------------------------------------------------------------
// imem_fetch_loader
// Instruction memory with a FETCH_W-word fetch port (1-cycle latency) and a
// valid/ready streaming program loader.
//   clk, rst_n            : clock, synchronous active-low reset
//   halt                  : freezes fetch outputs and blocks new reads
//   fetch_req, fetch_addr : read FETCH_W words starting at fetch_addr
//   fetch_valid, fetch_data : completed read, word k at [k*DATA_W +: DATA_W]
//   load_start, load_base, load_len : start a load (sampled in IDLE only)
//   load_valid, load_data, load_ready : load word stream handshake
//   load_busy             : loader in LOAD
//   load_done             : one-cycle pulse after the final beat
// ---------------------------------------------------------------------------
module imem_fetch_loader
   import imem_pkg::*;
#(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int FETCH_W = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        halt,
   input  logic                        fetch_req,
   input  logic [ADDR_W-1:0]           fetch_addr,
   output logic                        fetch_valid,
   output logic [FETCH_W*DATA_W-1:0]   fetch_data,
   input  logic                        load_start,
   input  logic [ADDR_W-1:0]           load_base,
   input  logic [ADDR_W:0]             load_len,
   input  logic                        load_valid,
   input  logic [DATA_W-1:0]           load_data,
   output logic                        load_ready,
   output logic                        load_busy,
   output logic                        load_done
);

   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int BANK_W = clog2_f(FETCH_W);
   localparam int OFF_W  = (BANK_W > 0) ? BANK_W : 1;
   localparam int ROW_W  = ADDR_W - BANK_W;
   localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);

   load_state_t         state_r, state_nx_s;
   logic [ADDR_W-1:0]   ptr_r, ptr_nx_s;
   logic [ADDR_W:0]     len_r, len_nx_s;
   logic [ADDR_W:0]     count_r, count_nx_s;
   logic                beat_s;
   logic                rd_en_s;
   logic [OFF_W-1:0]    rd_off_s, wr_off_s, off_r, sel_s;
   logic [ROW_W-1:0]    rd_row_s, wr_row_s;
   logic                fetch_valid_r, load_ready_r, load_busy_r, load_done_r;
   logic [DATA_W-1:0]   bank_rdata_s [FETCH_W];
   logic [FETCH_W*DATA_W-1:0] fetch_data_s;

   // load_ready_r is high exactly in LOAD, so it doubles as the state qualifier
   assign beat_s  = load_valid && load_ready_r;
   assign rd_en_s = fetch_req && !halt && (state_r != ST_LOAD);

   // Split addresses into bank offset (low bits) and row (high bits)
   assign rd_off_s = OFF_W'(fetch_addr % ADDR_W'(FETCH_W));
   assign rd_row_s = ROW_W'(fetch_addr >> BANK_W);
   assign wr_off_s = OFF_W'(ptr_r % ADDR_W'(FETCH_W));
   assign wr_row_s = ROW_W'(ptr_r >> BANK_W);

   // Loader next-state, pointer and beat counter
   always_comb begin
      state_nx_s = state_r;
      ptr_nx_s   = ptr_r;
      len_nx_s   = len_r;
      count_nx_s = count_r;
      case (state_r)
         ST_IDLE: begin
            if (load_start) begin
               ptr_nx_s   = load_base;
               len_nx_s   = (load_len > DEPTH_LEN) ? DEPTH_LEN : load_len;
               count_nx_s = '0;
               if (load_len == '0) begin
                  state_nx_s = ST_DONE;
               end else begin
                  state_nx_s = ST_LOAD;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (beat_s) begin
               ptr_nx_s   = ptr_r + ADDR_W'(1);   // natural wrap at DEPTH-1
               count_nx_s = count_r + (ADDR_W+1)'(1);
               if ((count_r + (ADDR_W+1)'(1)) == len_r) begin
                  state_nx_s = ST_DONE;
               end else begin
                  state_nx_s = ST_LOAD;
               end
            end else begin
               state_nx_s = ST_LOAD;
            end
         end
         ST_DONE: begin
            state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Loader state registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         ptr_r   <= '0;
         len_r   <= '0;
         count_r <= '0;
      end else begin
         state_r <= state_nx_s;
         ptr_r   <= ptr_nx_s;
         len_r   <= len_nx_s;
         count_r <= count_nx_s;
      end
   end

   // Registered status outputs, decoded from the next state so they line up with it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         load_ready_r <= 1'b0;
         load_busy_r  <= 1'b0;
         load_done_r  <= 1'b0;
      end else begin
         load_ready_r <= (state_nx_s == ST_LOAD);
         load_busy_r  <= (state_nx_s == ST_LOAD);
         load_done_r  <= (state_nx_s == ST_DONE);
      end
   end

   // Fetch valid and the start offset used to rotate bank outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_valid_r <= 1'b0;
         off_r         <= '0;
      end else if (halt) begin
         fetch_valid_r <= fetch_valid_r;
         off_r         <= off_r;
      end else if (state_r == ST_LOAD) begin
         fetch_valid_r <= 1'b0;
         off_r         <= off_r;
      end else begin
         fetch_valid_r <= fetch_req;
         if (fetch_req) begin
            off_r <= rd_off_s;
         end
      end
   end

   // Banks below the start offset hold words from the next row
   for (genvar b = 0; b < FETCH_W; b++) begin : g_bank
      logic [ROW_W-1:0] raddr_s;
      logic             we_s;

      assign raddr_s = (int'(rd_off_s) > b) ? (rd_row_s + ROW_W'(1)) : rd_row_s;
      assign we_s    = beat_s && rst_n && (int'(wr_off_s) == b);

      imem_bank #(
         .ROW_W  (ROW_W),
         .DATA_W (DATA_W)
      ) u_bank (
         .clk   (clk),
         .rst_n (rst_n),
         .re    (rd_en_s),
         .raddr (raddr_s),
         .we    (we_s),
         .waddr (wr_row_s),
         .wdata (load_data),
         .rdata (bank_rdata_s[b])
      );
   end

   // Rotate bank outputs so word k is the one at (start address + k)
   always_comb begin
      fetch_data_s = '0;
      sel_s        = '0;
      for (int k = 0; k < FETCH_W; k++) begin
         sel_s = off_r + OFF_W'(k);
         fetch_data_s[k*DATA_W +: DATA_W] = bank_rdata_s[sel_s];
      end
   end

   assign fetch_valid = fetch_valid_r;
   assign fetch_data  = fetch_data_s;
   assign load_ready  = load_ready_r;
   assign load_busy   = load_busy_r;
   assign load_done   = load_done_r;

endmodule

// File: tb/tb_imem_fetch_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_loader
// Directed bench for imem_fetch_loader (ADDR_W=9, DATA_W=32, FETCH_W=2).
// Status vectors below are {load_ready, load_busy, load_done, fetch_valid}.
// ---------------------------------------------------------------------------
module tb_imem_fetch_loader;

   localparam int ADDR_W  = 9;
   localparam int DATA_W  = 32;
   localparam int FETCH_W = 2;

   logic                      clk;
   logic                      rst_n;
   logic                      halt;
   logic                      fetch_req;
   logic [ADDR_W-1:0]         fetch_addr;
   logic                      fetch_valid;
   logic [FETCH_W*DATA_W-1:0] fetch_data;
   logic                      load_start;
   logic [ADDR_W-1:0]         load_base;
   logic [ADDR_W:0]           load_len;
   logic                      load_valid;
   logic [DATA_W-1:0]         load_data;
   logic                      load_ready;
   logic                      load_busy;
   logic                      load_done;

   int checks = 0;
   int errors = 0;

   imem_fetch_loader #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .FETCH_W (FETCH_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .halt        (halt),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_valid (fetch_valid),
      .fetch_data  (fetch_data),
      .load_start  (load_start),
      .load_base   (load_base),
      .load_len    (load_len),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .load_busy   (load_busy),
      .load_done   (load_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
      load_base  = base;
      load_len   = len;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic beat(input logic [DATA_W-1:0] d);
      load_valid = 1'b1;
      load_data  = d;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic fetch(input logic [ADDR_W-1:0] a);
      fetch_req  = 1'b1;
      fetch_addr = a;
      tick();
      fetch_req  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; load_start = 1'b1; load_base = 9'd0; load_len = 10'd4;
      tick(); tick();
      checks++;
      if ({load_ready, load_busy, load_done, fetch_valid} !== 4'b0000) begin
         errors++; $display("FAIL reset_status got %b exp %b", {load_ready, load_busy, load_done, fetch_valid}, 4'b0000);
      end
      checks++;
      if (fetch_data !== 64'h0) begin
         errors++; $display("FAIL reset_data got %h exp %h", fetch_data, 64'h0);
      end
      load_start = 1'b0; rst_n = 1'b1;
      tick();
      checks++;
      if ({load_ready, load_busy, load_done, fetch_valid} !== 4'b0000) begin
         errors++; $display("FAIL reset_idle got %b exp %b", {load_ready, load_busy, load_done, fetch_valid}, 4'b0000);
      end
   endtask

   task automatic test_basic_load();
      logic [3:0] exp_st;
      start_load(9'd0, 10'd4);
      checks++;
      if ({load_ready, load_busy, load_done, fetch_valid} !== 4'b1100) begin
         errors++; $display("FAIL basic_start got %b exp %b", {load_ready, load_busy, load_done, fetch_valid}, 4'b1100);
      end
      for (int i = 0; i < 4; i++) begin
         beat(32'hA0 + 32'(i));
         exp_st = (i == 3) ? 4'b0010 : 4'b1100;
         checks++;
         if ({load_ready, load_busy, load_done, fetch_valid} !== exp_st) begin
            errors++; $display("FAIL basic_beat%0d got %b exp %b", i, {load_ready, load_busy, load_done, fetch_valid}, exp_st);
         end
      end
      tick();
      checks++;
      if ({load_ready, load_busy, load_done, fetch_valid} !== 4'b0000) begin
         errors++; $display("FAIL basic_idle got %b exp %b", {load_ready, load_busy, load_done, fetch_valid}, 4'b0000);
      end
      fetch(9'd2);
      checks++;
      if (fetch_valid !== 1'b1 || fetch_data !== {32'hA3, 32'hA2}) begin
         errors++; $display("FAIL basic_fetch2 got %b %h exp 1 %h", fetch_valid, fetch_data, {32'hA3, 32'hA2});
      end
      tick();
      checks++;
      if (fetch_valid !== 1'b0 || fetch_data !== {32'hA3, 32'hA2}) begin
         errors++; $display("FAIL basic_hold got %b %h exp 0 %h", fetch_valid, fetch_data, {32'hA3, 32'hA2});
      end
      fetch(9'd1);
      checks++;
      if (fetch_valid !== 1'b1 || fetch_data !== {32'hA2, 32'hA1}) begin
         errors++; $display("FAIL basic_fetch1 got %b %h exp 1 %h", fetch_valid, fetch_data, {32'hA2, 32'hA1});
      end
   endtask

   task automatic test_wrap();
      start_load(9'd510, 10'd3);
      beat(32'hB0); beat(32'hB1); beat(32'hB2);
      checks++;
      if ({load_ready, load_busy, load_done, fetch_valid} !== 4'b0010) begin
         errors++; $display("FAIL wrap_done got %b exp %b", {load_ready, load_busy, load_done, fetch_valid}, 4'b0010);
      end
      tick();
      fetch(9'd511);
      checks++;
      if (fetch_data !== {32'hB2, 32'hB1}) begin
         errors++; $display("FAIL wrap_fetch511 got %h exp %h", fetch_data, {32'hB2, 32'hB1});
      end
      fetch(9'd510);
      checks++;
      if (fetch_data !== {32'hB1, 32'hB0}) begin
         errors++; $display("FAIL wrap_fetch510 got %h exp %h", fetch_data, {32'hB1, 32'hB0});
      end
      fetch(9'd0);
      checks++;
      if (fetch_data !== {32'hA1, 32'hB2}) begin
         errors++; $display("FAIL wrap_fetch0 got %h exp %h", fetch_data, {32'hA1, 32'hB2});
      end
   endtask

   task automatic test_backpressure();
      start_load(9'd20, 10'd4);
      beat(32'hD0); beat(32'hD1); beat(32'hD2); beat(32'hD3);
      tick();
      start_load(9'd20, 10'd2);
      beat(32'hC0);
      checks++;
      if ({load_ready, load_busy, load_done, fetch_valid} !== 4'b1100) begin
         errors++; $display("FAIL bp_beat1 got %b exp %b", {load_ready, load_busy, load_done, fetch_valid}, 4'b1100);
      end
      load_valid = 1'b0; load_data = 32'hC9;
      tick();
      checks++;
      if ({load_ready, load_busy, load_done, fetch_valid} !== 4'b1100) begin
         errors++; $display("FAIL bp_gap got %b exp %b", {load_ready, load_busy, load_done, fetch_valid}, 4'b1100);
      end
      beat(32'hC1);
      checks++;
      if ({load_ready, load_busy, load_done, fetch_valid} !== 4'b0010) begin
         errors++; $display("FAIL bp_done got %b exp %b", {load_ready, load_busy, load_done, fetch_valid}, 4'b0010);
      end
      tick();
      fetch(9'd20);
      checks++;
      if (fetch_data !== {32'hC1, 32'hC0}) begin
         errors++; $display("FAIL bp_fetch20 got %h exp %h", fetch_data, {32'hC1, 32'hC0});
      end
      fetch(9'd22);
      checks++;
      if (fetch_data !== {32'hD3, 32'hD2}) begin
         errors++; $display("FAIL bp_fetch22 got %h exp %h", fetch_data, {32'hD3, 32'hD2});
      end
   endtask

   task automatic test_zero_len();
      load_valid = 1'b1; load_data = 32'hEE;
      start_load(9'd22, 10'd0);
      checks++;
      if ({load_ready, load_busy, load_done, fetch_valid} !== 4'b0010) begin
         errors++; $display("FAIL zero_done got %b exp %b", {load_ready, load_busy, load_done, fetch_valid}, 4'b0010);
      end
      load_valid = 1'b0;
      tick();
      checks++;
      if ({load_ready, load_busy, load_done, fetch_valid} !== 4'b0000) begin
         errors++; $display("FAIL zero_idle got %b exp %b", {load_ready, load_busy, load_done, fetch_valid}, 4'b0000);
      end
      fetch(9'd22);
      checks++;
      if (fetch_data !== {32'hD3, 32'hD2}) begin
         errors++; $display("FAIL zero_nowrite got %h exp %h", fetch_data, {32'hD3, 32'hD2});
      end
   endtask

   task automatic test_halt();
      fetch(9'd0);
      checks++;
      if (fetch_valid !== 1'b1 || fetch_data !== {32'hA1, 32'hB2}) begin
         errors++; $display("FAIL halt_pre got %b %h exp 1 %h", fetch_valid, fetch_data, {32'hA1, 32'hB2});
      end
      halt = 1'b1; fetch_req = 1'b1; fetch_addr = 9'd2;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (fetch_valid !== 1'b1 || fetch_data !== {32'hA1, 32'hB2}) begin
            errors++; $display("FAIL halt_hold%0d got %b %h exp 1 %h", i, fetch_valid, fetch_data, {32'hA1, 32'hB2});
         end
      end
      halt = 1'b0;
      tick();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_data !== {32'hA3, 32'hA2}) begin
         errors++; $display("FAIL halt_release got %b %h exp 1 %h", fetch_valid, fetch_data, {32'hA3, 32'hA2});
      end
      fetch_req = 1'b0;
      tick();
      checks++;
      if (fetch_valid !== 1'b0) begin
         errors++; $display("FAIL halt_noreq got %b exp 0", fetch_valid);
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] exp_st;
      fetch_req = 1'b1; fetch_addr = 9'd2;
      load_base = 9'd40; load_len = 10'd4; load_start = 1'b1;
      tick();
      checks++;
      if ({load_ready, load_busy, load_done, fetch_valid} !== 4'b1101 || fetch_data !== {32'hA3, 32'hA2}) begin
         errors++; $display("FAIL sim_both got %b %h exp 1101 %h", {load_ready, load_busy, load_done, fetch_valid}, fetch_data, {32'hA3, 32'hA2});
      end
      load_start = 1'b0;
      tick();
      checks++;
      if ({load_ready, load_busy, load_done, fetch_valid} !== 4'b1100 || fetch_data !== {32'hA3, 32'hA2}) begin
         errors++; $display("FAIL sim_loadblk got %b %h exp 1100 %h", {load_ready, load_busy, load_done, fetch_valid}, fetch_data, {32'hA3, 32'hA2});
      end
      fetch_req = 1'b0;
      // a fresh start request mid-load must not restart the loader
      load_start = 1'b1; load_base = 9'd100; load_len = 10'd1;
      for (int i = 0; i < 4; i++) begin
         beat(32'hE0 + 32'(i));
         load_start = 1'b0;
         exp_st = (i == 3) ? 4'b0010 : 4'b1100;
         checks++;
         if ({load_ready, load_busy, load_done, fetch_valid} !== exp_st) begin
            errors++; $display("FAIL sim_beat%0d got %b exp %b", i, {load_ready, load_busy, load_done, fetch_valid}, exp_st);
         end
      end
      tick();
      fetch(9'd40);
      checks++;
      if (fetch_data !== {32'hE1, 32'hE0}) begin
         errors++; $display("FAIL sim_fetch40 got %h exp %h", fetch_data, {32'hE1, 32'hE0});
      end
      fetch(9'd42);
      checks++;
      if (fetch_data !== {32'hE3, 32'hE2}) begin
         errors++; $display("FAIL sim_fetch42 got %h exp %h", fetch_data, {32'hE3, 32'hE2});
      end
   endtask

   task automatic test_reset_mid_load();
      start_load(9'd60, 10'd4);
      beat(32'hF0); beat(32'hF1);
      rst_n = 1'b0; load_valid = 1'b1; load_data = 32'hF2;
      tick();
      checks++;
      if ({load_ready, load_busy, load_done, fetch_valid} !== 4'b0000) begin
         errors++; $display("FAIL rml_reset got %b exp %b", {load_ready, load_busy, load_done, fetch_valid}, 4'b0000);
      end
      rst_n = 1'b1; load_valid = 1'b0;
      tick();
      checks++;
      if ({load_ready, load_busy, load_done, fetch_valid} !== 4'b0000) begin
         errors++; $display("FAIL rml_nodone got %b exp %b", {load_ready, load_busy, load_done, fetch_valid}, 4'b0000);
      end
      fetch(9'd60);
      checks++;
      if (fetch_data !== {32'hF1, 32'hF0}) begin
         errors++; $display("FAIL rml_fetch60 got %h exp %h", fetch_data, {32'hF1, 32'hF0});
      end
      fetch(9'd2);
      checks++;
      if (fetch_data !== {32'hA3, 32'hA2}) begin
         errors++; $display("FAIL rml_retained got %h exp %h", fetch_data, {32'hA3, 32'hA2});
      end
   endtask

   initial begin
      rst_n = 1'b0; halt = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
      load_start = 1'b0; load_base = '0; load_len = '0;
      load_valid = 1'b0; load_data = '0;
      test_reset();
      test_basic_load();
      test_wrap();
      test_backpressure();
      test_zero_len();
      test_halt();
      test_simultaneous();
      test_reset_mid_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
